// File: rtl/cart_sig_scanner.sv
// cart_sig_scanner: counts byte-signature occurrences in a cart download and resolves a bankswitch code.
// Superchip CRC detection is built only when CART_SC_DETECT_EN is defined; otherwise sc is tied 0.
module cart_sig_scanner #(
    parameter int ADDR_W   = 16,
    parameter int NUM_SIGS = 16,
    parameter int MAX_LEN  = 5,
    parameter logic [NUM_SIGS*MAX_LEN*8-1:0] SIGS     = '0,
    parameter logic [NUM_SIGS*4-1:0]         SIG_LEN  = '0,
    parameter logic [NUM_SIGS*8-1:0]         SIG_NEED = '0,
    parameter logic [NUM_SIGS*4-1:0]         SIG_BS   = '0,
    parameter logic [NUM_SIGS*NUM_SIGS-1:0]  SIG_VETO = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                enable,
    input  logic [7:0]          data,
    input  logic                done,
    output logic                busy,
    output logic                valid,
    output logic [3:0]          force_bs,
    output logic                sc,
    output logic [NUM_SIGS-1:0] sig_hits
);
    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, DONE} state_t;
    state_t r_state, w_next;
    logic [MAX_LEN*8-1:0]     r_hist, w_hist;
    logic [3:0]               r_seen, w_seen;
    logic [7:0]               r_cnt [NUM_SIGS];
    logic [7:0]               w_cnt [NUM_SIGS];
    logic [7:0]               w_base;
    logic [(MAX_LEN+1)*8-1:0] w_win;
    logic [NUM_SIGS-1:0]      w_match, w_raw, w_hit;
    logic [3:0]               w_bs;
    logic                     w_restart, w_byte, w_sc;

    always_comb begin
        w_restart = enable && (r_state == IDLE || r_state == DONE || (r_state == SCAN && addr == '0));
        w_byte    = enable && r_state != RESOLVE;
        w_hist    = w_restart ? '0 : r_hist;
        w_seen    = w_restart ? '0 : r_seen;
        w_win     = {w_hist, data};
        w_match   = '1;
        w_raw     = '0;
        w_hit     = '0;
        w_bs      = 4'd0;
        w_base    = 8'd0;
        for (int i = 0; i < NUM_SIGS; i++) begin
            if (int'(w_seen) + 1 < int'(SIG_LEN[i*4+:4])) w_match[i] = 1'b0;
            for (int k = 0; k < MAX_LEN; k++)
                if (k < int'(SIG_LEN[i*4+:4]) && w_win[k*8+:8] != SIGS[(i*MAX_LEN+k)*8+:8]) w_match[i] = 1'b0;
            w_base   = w_restart ? 8'd0 : r_cnt[i];
            w_cnt[i] = (w_match[i] && w_base != 8'hFF) ? w_base + 8'd1 : w_base;
            w_raw[i] = r_cnt[i] >= SIG_NEED[i*8+:8];
        end
        for (int i = 0; i < NUM_SIGS; i++)
            w_hit[i] = w_raw[i] & ~|(w_raw & SIG_VETO[i*NUM_SIGS+:NUM_SIGS]);
        // Walk downward so the lowest-index hit is the one left standing
        for (int i = NUM_SIGS - 1; i >= 0; i--)
            if (w_hit[i]) w_bs = SIG_BS[i*4+:4];
        w_next = w_restart ? SCAN :
                 (r_state == SCAN && done) ? RESOLVE :
                 (r_state == RESOLVE) ? DONE : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hist   <= '0;
            r_seen   <= '0;
            for (int i = 0; i < NUM_SIGS; i++) r_cnt[i] <= 8'd0;
            force_bs <= 4'd0;
            sc       <= 1'b0;
            sig_hits <= '0;
        end else begin
            r_state <= w_next;
            if (w_byte) begin
                r_hist <= w_win[MAX_LEN*8-1:0];
                r_seen <= (int'(w_seen) < MAX_LEN) ? w_seen + 4'd1 : w_seen;
                r_cnt  <= w_cnt;
            end
            if (w_restart) begin
                force_bs <= 4'd0;
                sc       <= 1'b0;
                sig_hits <= '0;
            end else if (r_state == RESOLVE) begin
                force_bs <= w_bs;
                sc       <= w_sc;
                sig_hits <= w_hit;
            end
        end
    end

    assign busy  = r_state == SCAN || r_state == RESOLVE;
    assign valid = r_state == DONE;

`ifdef CART_SC_DETECT_EN
    logic [31:0] r_crc_a, r_crc_b, w_crc_a, w_crc_b;
    logic        r_sc_fail, r_sc_any, w_sc_fail, w_sc_any;
    logic [11:0] w_off;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always_comb begin
        w_off     = addr[11:0];
        w_crc_a   = w_restart ? 32'hFFFFFFFF : r_crc_a;
        w_crc_b   = w_restart ? 32'hFFFFFFFF : r_crc_b;
        w_sc_fail = w_restart ? 1'b0 : r_sc_fail;
        w_sc_any  = w_restart ? 1'b0 : r_sc_any;
    end

    // A Superchip bank mirrors its first 128 bytes into the next 128 (the RAM window)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_a   <= 32'hFFFFFFFF;
            r_crc_b   <= 32'hFFFFFFFF;
            r_sc_fail <= 1'b0;
            r_sc_any  <= 1'b0;
        end else if (w_byte) begin
            r_crc_a   <= w_off == 12'h000 ? crc_byte(32'hFFFFFFFF, data) :
                         w_off < 12'h080 ? crc_byte(w_crc_a, data) : w_crc_a;
            r_crc_b   <= w_off == 12'h000 ? 32'hFFFFFFFF :
                         (w_off >= 12'h080 && w_off < 12'h100) ? crc_byte(w_crc_b, data) : w_crc_b;
            r_sc_any  <= w_sc_any | (w_off == 12'h100);
            r_sc_fail <= w_sc_fail | (w_off == 12'h100 && w_crc_a != w_crc_b);
        end
    end

    assign w_sc = r_sc_any & ~r_sc_fail;
`else
    assign w_sc = 1'b0;
`endif
endmodule

// File: tb/tb_cart_sig_scanner.sv
// tb_cart_sig_scanner: directed vectors for the signature scanner with hand-computed expectations.
module tb_cart_sig_scanner;
    localparam int NS = 4;
    localparam int ML = 5;
    // 0: E0 8D E0 1F, 1: F8 8D F9 1F (need 2), 2: FE 20 00 D0 C6 C5 (vetoed by F8), 3: 3F 85 3F (need 2)
    localparam logic [NS*ML*8-1:0] P_SIGS = {40'h000000853F, 40'h2000D0C6C5, 40'h00008DF91F, 40'h00008DE01F};
    localparam logic [NS*4-1:0]    P_LEN  = {4'd2, 4'd5, 4'd3, 4'd3};
    localparam logic [NS*8-1:0]    P_NEED = {8'd2, 8'd1, 8'd2, 8'd1};
    localparam logic [NS*4-1:0]    P_BS   = {4'd5, 4'd3, 4'd1, 4'd4};
    localparam logic [NS*NS-1:0]   P_VETO = {4'b0000, 4'b0010, 4'b0000, 4'b0000};
`ifdef CART_SC_DETECT_EN
    localparam logic SC_GOOD = 1'b1;
`else
    localparam logic SC_GOOD = 1'b0;
`endif

    logic clk = 1'b0, reset, enable, done, busy, valid, sc;
    logic [15:0] addr;
    logic [7:0] data;
    logic [3:0] force_bs;
    logic [NS-1:0] sig_hits;
    int n_chk = 0, n_err = 0;

    cart_sig_scanner #(.ADDR_W(16), .NUM_SIGS(NS), .MAX_LEN(ML), .SIGS(P_SIGS), .SIG_LEN(P_LEN),
        .SIG_NEED(P_NEED), .SIG_BS(P_BS), .SIG_VETO(P_VETO)) dut (
        .clk(clk), .reset(reset), .addr(addr), .enable(enable), .data(data), .done(done),
        .busy(busy), .valid(valid), .force_bs(force_bs), .sc(sc), .sig_hits(sig_hits));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        data = d;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic stream(input logic [15:0] a0, input int n, input logic [87:0] b);
        for (int k = 0; k < n; k++) put(a0 + 16'(k), b[(n-1-k)*8+:8]);
    endtask

    task automatic finish_img(input string tag, input logic [3:0] bs, input logic [NS-1:0] hits);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check({tag, "_valid_early"}, 32'(valid), 32'd0);
        check({tag, "_busy_resolve"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_force_bs"}, 32'(force_bs), 32'(bs));
        check({tag, "_sig_hits"}, 32'(sig_hits), 32'(hits));
    endtask

    task automatic sc_image(input string tag, input logic [15:0] flip_at, input logic exp);
        for (int a = 0; a < 8192; a++)
            put(16'(a), ({1'b0, 7'(a)} ^ (a >= 4096 ? 8'h35 : 8'h00)) ^ (16'(a) == flip_at ? 8'h01 : 8'h00));
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_sc"}, 32'(sc), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; done = 1'b0; addr = '0; data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_force_bs", 32'(force_bs), 32'd0);
        check("rst_sc", 32'(sc), 32'd0);
        check("rst_hits", 32'(sig_hits), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        stream(16'h0123, 3, 88'h8DE01F);
        check("e0_busy", 32'(busy), 32'd1);
        finish_img("e0", 4'd4, 4'b0001);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("done_idle_valid", 32'(valid), 32'd1);
        check("done_idle_busy", 32'(busy), 32'd0);
        stream(16'h0, 11, 88'h2000D0C6C5_8DF91F_8DF91F);
        finish_img("veto", 4'd1, 4'b0010);
        stream(16'h0, 8, 88'h2000D0C6C5_8DF91F);
        finish_img("noveto", 4'd3, 4'b0100);
        stream(16'h0, 2, 88'h853F);
        finish_img("thr1", 4'd0, 4'b0000);
        stream(16'h0, 4, 88'h853F853F);
        finish_img("thr2", 4'd5, 4'b1000);
        stream(16'h0, 7, 88'h853F_8DE01F_853F);
        finish_img("prio", 4'd4, 4'b1001);
        for (int k = 0; k < 257; k++) begin
            put(16'(2 * k), 8'h85);
            put(16'(2 * k + 1), 8'h3F);
        end
        finish_img("sat", 4'd5, 4'b1000);
        stream(16'h0010, 2, 88'h8DE0);
        put(16'h0, 8'h1F);
        finish_img("split", 4'd0, 4'b0000);
        stream(16'h0020, 2, 88'h8DE0);
        addr = 16'h0; data = 8'h1F; enable = 1'b1; done = 1'b1;
        @(negedge clk);
        enable = 1'b0; done = 1'b0;
        check("rdone_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("rdone_valid", 32'(valid), 32'd0);
        check("rdone_busy2", 32'(busy), 32'd1);
        finish_img("rdone", 4'd0, 4'b0000);
        sc_image("sc_good", 16'hFFFF, SC_GOOD);
        sc_image("sc_flip", 16'h1090, 1'b0);
        for (int k = 0; k < 100; k++) put(16'(k), (k % 3 == 0) ? 8'h8D : (k % 3 == 1) ? 8'hE0 : 8'h1F);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        stream(16'h0123, 3, 88'h8DE01F);
        finish_img("post_rst", 4'd4, 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_done_valid", 32'(valid), 32'd0);
        check("rst_done_bs", 32'(force_bs), 32'd0);
        check("rst_done_hits", 32'(sig_hits), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
